// File: rtl/aes_byte_display_seq.sv
// Purpose: steps through the 16 bytes of a captured AES block and turns each byte into three BCD digits for the display.
// Latency: a load or advance sampled on edge N updates word/byte_idx/valid after edge N+8 (one double-dabble iteration per cycle).
// Backpressure: none; next arriving outside SHOW is dropped, and load always wins and restarts from byte 0.
// Optional feature: define AES_DISP_AUTO_ADVANCE_EN to build the dwell timer that auto-advances every DWELL_CYCLES cycles.
module aes_byte_display_seq #(
  parameter int unsigned DWELL_CYCLES = 50_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] data_in,
  input  logic         load,
  input  logic         next,
  output logic [11:0]  word,
  output logic [3:0]   byte_idx,
  output logic         valid,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_SHOW = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [127:0]  block_q, block_d;
  logic [3:0]    idx_q, idx_d;
  // Double-dabble register: [19:8] BCD digits, [7:0] binary still to shift in.
  logic [19:0]   sr_q, sr_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [11:0]   word_q, word_d;
  logic [3:0]    byte_idx_q, byte_idx_d;
  logic          valid_q, valid_d;

  logic [19:0]   sr_step;
  logic [3:0]    adv_idx;
  logic          dwell_hit;
  logic          dwell_clr;

  // Byte 0 sits in the top byte of the block, byte 15 in the bottom byte.
  function automatic logic [7:0] sel_byte(input logic [127:0] blk, input logic [3:0] idx);
    logic [6:0] base;
    base = {~idx, 3'b000};
    return blk[base +: 8];
  endfunction

  // One add-3/shift iteration: correct every BCD nibble >= 5, then shift left by one.
  function automatic logic [19:0] dabble_step(input logic [19:0] sr);
    logic [19:0] adj;
    adj = sr;
    for (int d = 0; d < 3; d++) begin
      if (adj[8 + 4*d +: 4] >= 4'd5) begin
        adj[8 + 4*d +: 4] = adj[8 + 4*d +: 4] + 4'd3;
      end
    end
    return {adj[18:0], 1'b0};
  endfunction

  assign sr_step = dabble_step(sr_q);
  assign adv_idx = idx_q + 4'd1;

  // Next-state logic: load overrides everything, then the per-state behaviour.
  always_comb begin
    state_d    = state_q;
    block_d    = block_q;
    idx_d      = idx_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    valid_d    = valid_q;
    dwell_clr  = 1'b0;

    if (load) begin
      // word is left alone so the display keeps its last digits while the new block converts.
      block_d = data_in;
      idx_d   = 4'd0;
      sr_d    = {12'h000, data_in[127:120]};
      cnt_d   = 3'd0;
      valid_d = 1'b0;
      state_d = S_CONV;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_CONV: begin
          sr_d  = sr_step;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            word_d     = sr_step[19:8];
            byte_idx_d = idx_q;
            valid_d    = 1'b1;
            dwell_clr  = 1'b1;
            state_d    = S_SHOW;
          end
        end
        S_SHOW: begin
          // Displayed word/byte_idx/valid stay put during the next conversion to avoid flicker.
          if (next || dwell_hit) begin
            idx_d   = adv_idx;
            sr_d    = {12'h000, sel_byte(block_q, adv_idx)};
            cnt_d   = 3'd0;
            state_d = S_CONV;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; reset blanks the display (0xFFF).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      block_q    <= '0;
      idx_q      <= 4'd0;
      sr_q       <= '0;
      cnt_q      <= 3'd0;
      word_q     <= 12'hFFF;
      byte_idx_q <= 4'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      block_q    <= block_d;
      idx_q      <= idx_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      valid_q    <= valid_d;
    end
  end

`ifdef AES_DISP_AUTO_ADVANCE_EN
  localparam logic [31:0] DwellLast = 32'(DWELL_CYCLES - 1);

  logic [31:0] dwell_q, dwell_d;

  // Advance on the SHOW cycle where the counter reaches DWELL_CYCLES-1.
  assign dwell_hit = (state_q == S_SHOW) && (dwell_q == DwellLast);

  // Dwell counter: zeroed on SHOW entry, counts every SHOW cycle.
  always_comb begin
    dwell_d = dwell_q;
    if (dwell_clr) begin
      dwell_d = 32'd0;
    end else if (state_q == S_SHOW) begin
      dwell_d = dwell_q + 32'd1;
    end
  end

  // Dwell counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_q <= 32'd0;
    end else begin
      dwell_q <= dwell_d;
    end
  end
`else
  // No dwell timer: SHOW holds until next. DWELL_CYCLES is accepted but has no effect.
  logic [32:0] dwell_unused;
  assign dwell_hit    = 1'b0;
  assign dwell_unused = {dwell_clr, 32'(DWELL_CYCLES)};
`endif

  assign word     = word_q;
  assign byte_idx = byte_idx_q;
  assign valid    = valid_q;
  assign busy     = (state_q == S_CONV);

endmodule

// File: tb/tb_aes_byte_display_seq.sv
`timescale 1ns/1ps
module tb_aes_byte_display_seq;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] data_in;
  logic         load;
  logic         next;
  logic [11:0]  word;
  logic [3:0]   byte_idx;
  logic         valid;
  logic         busy;

  aes_byte_display_seq #(.DWELL_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .load     (load),
    .next     (next),
    .word     (word),
    .byte_idx (byte_idx),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] word;
    logic [3:0]  idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Test block bytes and their hand-computed decimal (BCD) values.
  logic [7:0]  bytes_a [16] = '{8'hFF, 8'h00, 8'h7B, 8'h09, 8'h0A, 8'h63, 8'h64, 8'h80,
                                8'h01, 8'hFE, 8'h32, 8'h0F, 8'hA5, 8'hE7, 8'h14, 8'hC8};
  logic [11:0] bcd_a   [16] = '{12'h255, 12'h000, 12'h123, 12'h009, 12'h010, 12'h099, 12'h100, 12'h128,
                                12'h001, 12'h254, 12'h050, 12'h015, 12'h165, 12'h231, 12'h020, 12'h200};
  logic [127:0] blk_a;
  logic [127:0] blk_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // gap posedges pass, next is raised, and the following posedge samples it.
  task automatic strobe_next(input int gap);
    repeat (gap) @(posedge clk);
    #1 next = 1'b1;
    @(posedge clk);
    #1 next = 1'b0;
  endtask

  task automatic strobe_load(input logic [127:0] d, input int gap);
    repeat (gap) @(posedge clk);
    #1 data_in = d;
    load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  // Monitor: every completed conversion (busy falling) is compared against the scoreboard.
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset && busy_prev && !busy) begin
      if (exp_q.size() == 0) begin
        check("unexpected result present", {20'd0, word}, 32'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("result word", {20'd0, word}, {20'd0, e.word});
        check("result byte_idx", {28'd0, byte_idx}, {28'd0, e.idx});
        check("result valid", {31'd0, valid}, 32'd1);
      end
    end
    busy_prev = busy;
  end

  initial begin
    reset   = 1'b1;
    load    = 1'b0;
    next    = 1'b0;
    data_in = '0;
    blk_a   = '0;
    for (int i = 0; i < 16; i++) blk_a = {blk_a[119:0], bytes_a[i]};
    blk_b = {8'h64, blk_a[119:0]};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset word", {20'd0, word}, 32'hFFF);
    check("reset byte_idx", {28'd0, byte_idx}, 32'd0);
    check("reset valid", {31'd0, valid}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);

    // Idle with stray next pulses: nothing may happen.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 next = (i % 4 == 1);
    end
    #1 next = 1'b0;
    @(negedge clk);
    check("idle word", {20'd0, word}, 32'hFFF);
    check("idle valid", {31'd0, valid}, 32'd0);
    check("idle busy", {31'd0, busy}, 32'd0);

    // First block: byte 0 = 0xFF -> 255 after exactly 8 busy cycles.
    exp_q.push_back('{word: 12'h255, idx: 4'd0});
    strobe_load(blk_a, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("first conv busy", {31'd0, busy}, 32'd1);
      check("first conv valid low", {31'd0, valid}, 32'd0);
      check("first conv word held", {20'd0, word}, 32'hFFF);
    end
    @(negedge clk);
    check("first result busy low", {31'd0, busy}, 32'd0);
    check("first result valid", {31'd0, valid}, 32'd1);

`ifdef AES_DISP_AUTO_ADVANCE_EN
    // Auto-advance: byte_idx steps every 12 cycles (4 dwell + 8 conversion) and wraps.
    for (int k = 1; k <= 16; k++) exp_q.push_back('{word: bcd_a[k % 16], idx: 4'(k % 16)});
    for (int k = 1; k <= 16; k++) begin
      repeat (11) @(negedge clk);
      check("dwell idx before step", {28'd0, byte_idx}, 32'((k - 1) % 16));
      @(negedge clk);
      check("dwell idx after step", {28'd0, byte_idx}, 32'(k % 16));
    end
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("mid-run reset word", {20'd0, word}, 32'hFFF);
    check("mid-run reset busy", {31'd0, busy}, 32'd0);
`else
    // Walk bytes 1..15 and wrap to 0 with next pulses 10 cycles apart.
    for (int k = 1; k <= 16; k++) begin
      exp_q.push_back('{word: bcd_a[k % 16], idx: 4'(k % 16)});
      strobe_next(k == 1 ? 1 : 9);
      @(negedge clk);
      check("no flicker word", {20'd0, word}, {20'd0, bcd_a[k - 1]});
      check("no flicker idx", {28'd0, byte_idx}, 32'(k - 1));
      check("advance busy", {31'd0, busy}, 32'd1);
    end
    // A next 3 cycles after an accepted one lands in CONV and must be dropped.
    strobe_next(2);
    repeat (20) @(negedge clk);
    check("dropped next idx", {28'd0, byte_idx}, 32'd0);
    check("dropped next word", {20'd0, word}, 32'h255);
    check("dropped next busy", {31'd0, busy}, 32'd0);

    // Abort: start a conversion, then load at its 4th cycle with byte0 = 0x64.
    strobe_next(1);
    exp_q.push_back('{word: 12'h100, idx: 4'd0});
    strobe_load(blk_b, 3);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort valid low", {31'd0, valid}, 32'd0);
      check("abort busy", {31'd0, busy}, 32'd1);
      check("abort word held", {20'd0, word}, 32'h255);
    end
    @(negedge clk);
    check("abort result valid", {31'd0, valid}, 32'd1);
    check("abort result word", {20'd0, word}, 32'h100);

    // Without auto-advance the byte stays displayed indefinitely.
    for (int i = 0; i < 10; i++) begin
      repeat (10) @(negedge clk);
      check("hold idx", {28'd0, byte_idx}, 32'd0);
      check("hold busy", {31'd0, busy}, 32'd0);
    end
`endif

    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_byte_display_seq.md
# aes_byte_display_seq

Display sequencer between the AES core's 128-bit output and the three-digit seven-segment decoder. It captures one 128-bit block and walks through its 16 bytes. Each byte is converted to three BCD digits with a sequential double-dabble (add-3/shift) engine, and the 12-bit BCD word is presented to the decoder. Byte advance comes from a user step pulse or, optionally, a dwell timer.

## Interface
Parameters:
- DWELL_CYCLES, 50_000_000, clock cycles each byte stays displayed before auto-advance; legal range 2..2^32-1; used only with auto-advance compiled in.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  128  AES block; byte 0 = data_in[127:120], byte 15 = data_in[7:0].
- load  input  1  single-cycle pulse; captures data_in and restarts at byte 0.
- next  input  1  single-cycle pulse; advance to next byte. Externally debounced and edge-detected.
- word  output  12  BCD digits to the decoder: [11:8] hundreds, [7:4] tens, [3:0] units.
- byte_idx  output  4  index of the byte currently shown in word.
- valid  output  1  word holds a completed conversion of the current block.
- busy  output  1  conversion in progress.

## Operation
- Registers: 128-bit block, 4-bit index, 20-bit double-dabble shift register (12 BCD + 8 binary), 3-bit iteration count, 32-bit dwell counter, word.
- States:
  - IDLE: after reset. Only load is acted on.
  - CONV: 8 add-3/shift iterations.
  - SHOW: holding a result.
- load, any state: capture data_in, index←0, load byte 0 into shift-register low 8 bits (BCD field cleared), count←0, valid←0, state←CONV. word keeps its prior value.
- CONV, each cycle:
  - Add 3 to every BCD nibble ≥5.
  - Shift the 20-bit register left by one.
  - count++.
  - On the 8th iteration: word←new BCD field, byte_idx←index, valid←1, dwell counter←0, state←SHOW.
- SHOW:
  - Advance on next, or on dwell expiry when compiled in.
  - Advance: index←index+1 mod 16 (15 wraps to 0), load that byte, count←0, state←CONV.
  - word, byte_idx and valid hold during the new conversion, so the display does not flicker.
- Priority: reset > load > next/dwell.
- next in IDLE or CONV is dropped, not queued.
- Result is always ≤ 0x255. Nibbles never exceed 9, so the decoder never blanks a digit after a conversion.

## Timing
- Reset values: word = 12'hFFF (all digits blank at the decoder), byte_idx = 0, valid = 0, busy = 0, state IDLE, dwell counter 0.
- Latency: load or advance sampled at edge N gives the updated word/byte_idx/valid visible after edge N+8.
- busy = 1 exactly for the cycles the state is CONV (8 cycles per byte).
- Minimum spacing between accepted next pulses is 9 cycles; pulses arriving sooner are ignored.
- load during CONV aborts the conversion in flight; the 8-cycle latency restarts from the load edge.
- Dwell:
  - The counter increments each SHOW cycle.
  - Advance occurs on the edge where the counter equals DWELL_CYCLES-1, so a byte is displayed for DWELL_CYCLES cycles in SHOW, plus 8 conversion cycles before the next byte appears.
  - next in SHOW advances immediately and the dwell counter is cleared on the next SHOW entry.
- Reset asserted mid-conversion returns to reset values immediately, independent of clk.

## Configuration
- AES_DISP_AUTO_ADVANCE_EN defined: dwell counter present; SHOW advances on next or dwell expiry, cycling the 16 bytes continuously.
- AES_DISP_AUTO_ADVANCE_EN undefined: no dwell counter is built, and DWELL_CYCLES is ignored. SHOW advances only on next, so a byte stays displayed indefinitely.

## Test plan
- Reset, then idle for 20 cycles → word = 0xFFF, valid = 0, busy = 0; next pulses ignored.
- data_in byte0 = 0xFF, load at edge N → busy for 8 cycles, then word = 0x255, byte_idx = 0, valid = 1 after edge N+8.
- Bytes 1..3 = 0x00, 0x7B, 0x09; three next pulses spaced 10 cycles apart → word = 0x000, 0x123, 0x009 in turn, with byte_idx 1, 2, 3.
- From byte_idx = 15, issue next → byte_idx = 0 and word = conversion of byte 0. A next issued 3 cycles after an accepted one is dropped.
- load at cycle 4 of a CONV, with new byte0 = 0x64 → conversion restarts; word = 0x100 eight cycles after load. valid is 0 from the load until then; no intermediate value appears.
- With AES_DISP_AUTO_ADVANCE_EN and DWELL_CYCLES = 4: after the first result, byte_idx steps every 12 cycles (4 dwell + 8 conversion) through 0..15 and wraps. Without the macro, byte_idx stays at 0 for 100 cycles.
